// File: rtl/abm_merge_reader_if.sv
// AXI4 bundle between the ABM merge reader and its bus master.
// Only the channels the reader uses are carried, plus the sidebands it ignores.
interface abm_merge_reader_if #(
    parameter int DW  = 512,
    parameter int IDW = 4
);
    // Read address channel
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [IDW-1:0]  arid;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic [3:0]      arqos;
    logic            arvalid;
    logic            arready;
    // Read data channel
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic [IDW-1:0]  rid;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    // Write address channel
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [IDW-1:0]  awid;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic [3:0]      awqos;
    logic            awvalid;
    logic            awready;
    // Write data channel
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    // Write response channel
    logic [1:0]      bresp;
    logic [IDW-1:0]  bid;
    logic            bvalid;
    logic            bready;

    modport master (
        output araddr, arlen, arid, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rdata, rresp, rid, rlast, rvalid,
        output rready,
        output awaddr, awlen, awid, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arid, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rdata, rresp, rid, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awid, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready
    );
endinterface

// File: rtl/abm_merge_reader.sv
// ABM merge reader: AXI4 read slave returning the bitwise merge of NRAM
// banks read at a common word address. Reads are pipelined with a credit
// scheme sized so the return FIFO can never overflow; writes are refused
// with SLVERR.
module abm_merge_reader #(
    parameter int DW     = 512,
    parameter int AW     = 14,
    parameter int NRAM   = 2,
    parameter int RD_LAT = 1,
    parameter int IDW    = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           merge_mode,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_rden,
    input  logic [NRAM*DW-1:0]   ram_data,
    abm_merge_reader_if.slave    axi
);
    localparam int LSB = $clog2(DW / 8);
    localparam int FD  = RD_LAT + 2;
    localparam int CW  = $clog2(FD + 1);
    localparam int PW  = $clog2(FD);

    typedef enum logic {RD_IDLE, RD_ISSUE} rd_state_t;
    typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wr_state_t;

    typedef struct packed {
        logic           valid;
        logic           last;
        logic           err;
        logic [IDW-1:0] id;
        logic [1:0]     mode;
    } tag_t;

    logic            active;
    rd_state_t       rd_state, rd_next;
    wr_state_t       wr_state, wr_next;
    logic [AW-1:0]   word;
    logic [8:0]      remaining;
    logic [IDW-1:0]  burst_id;
    logic [1:0]      burst_mode;
    logic            burst_err;
    logic            ar_fire, issue;
    logic [CW-1:0]   credit, count;
    tag_t            tag_pipe [RD_LAT];
    tag_t            new_tag, tag_out;
    logic [DW-1:0]   merged;
    logic [DW-1:0]   fifo_data [FD];
    logic            fifo_last [FD];
    logic            fifo_err  [FD];
    logic [IDW-1:0]  fifo_id   [FD];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    logic            aw_fire, w_fire, b_fire;
    logic [IDW-1:0]  write_id;
    logic            unused;

    // Sidebands and write payload are accepted but have no effect.
    assign unused = &{1'b0, axi.araddr[LSB-1:0], axi.arsize, axi.arburst, axi.arlock,
                      axi.arcache, axi.arprot, axi.arqos, axi.awaddr, axi.awlen,
                      axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot,
                      axi.awqos, axi.wdata, axi.wstrb};

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Held low through reset so the ready signals only rise one clock after release.
    always_ff @(posedge clk) begin
        active <= resetn;
    end

    // Issue engine state register.
    always_ff @(posedge clk) begin
        if (!resetn) rd_state <= RD_IDLE;
        else         rd_state <= rd_next;
    end

    // Issue engine next state: leave ISSUE right after the last word goes out.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE:  if (ar_fire) rd_next = RD_ISSUE;
            RD_ISSUE: if (issue && remaining == 9'd1) rd_next = RD_IDLE;
            default:  rd_next = RD_IDLE;
        endcase
    end

    // Issue engine outputs: a read goes out only while credit remains.
    always_comb begin
        axi.arready = 1'b0;
        issue       = 1'b0;
        if (active) begin
            case (rd_state)
                RD_IDLE:  axi.arready = 1'b1;
                RD_ISSUE: issue = (credit < CW'(FD));
                default:  ;
            endcase
        end
        ram_rden = issue;
        ram_addr = word;
    end

    assign ar_fire = axi.arvalid && axi.arready;

    // Burst context: captured on AR, then the word walks (wrapping) as reads issue.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            word       <= '0;
            remaining  <= '0;
            burst_id   <= '0;
            burst_mode <= '0;
            burst_err  <= 1'b0;
        end else if (ar_fire) begin
            word       <= axi.araddr[LSB +: AW];
            remaining  <= {1'b0, axi.arlen} + 9'd1;
            burst_id   <= axi.arid;
            burst_mode <= merge_mode;
            burst_err  <= |axi.araddr[31:AW+LSB];
        end else if (issue) begin
            word       <= word + AW'(1);
            remaining  <= remaining - 9'd1;
        end
    end

    // Tag that travels alongside the read issued this cycle.
    always_comb begin
        new_tag.valid = issue;
        new_tag.last  = (remaining == 9'd1);
        new_tag.err   = burst_err;
        new_tag.id    = burst_id;
        new_tag.mode  = burst_mode;
    end

    // Tag shift register matching the RAM read latency.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= new_tag;
            for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_out = tag_pipe[RD_LAT-1];

    // Bank merge for the emerging tag; mode 3 keeps bank 0 alone.
    always_comb begin
        merged = ram_data[0 +: DW];
        for (int k = 1; k < NRAM; k++) begin
            case (tag_out.mode)
                2'd0:    merged = merged | ram_data[k*DW +: DW];
                2'd1:    merged = merged & ram_data[k*DW +: DW];
                2'd2:    merged = merged ^ ram_data[k*DW +: DW];
                default: ;
            endcase
        end
    end

    assign push = tag_out.valid;
    assign pop  = axi.rvalid && axi.rready;

    // Return FIFO storage; contents are only meaningful under the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= merged;
            fifo_last[wr_ptr] <= tag_out.last;
            fifo_err[wr_ptr]  <= tag_out.err;
            fifo_id[wr_ptr]   <= tag_out.id;
        end
    end

    // FIFO pointers, occupancy and read credit (in-flight plus buffered beats).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            credit <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            case ({issue, pop})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: ;
            endcase
        end
    end

    // R channel is driven straight from the FIFO head.
    always_comb begin
        axi.rvalid = (count != '0);
        axi.rdata  = fifo_data[rd_ptr];
        axi.rresp  = fifo_err[rd_ptr] ? 2'b10 : 2'b00;
        axi.rid    = fifo_id[rd_ptr];
        axi.rlast  = fifo_last[rd_ptr];
    end

    // Write channel state register.
    always_ff @(posedge clk) begin
        if (!resetn) wr_state <= W_ADDR;
        else         wr_state <= wr_next;
    end

    // Write channel next state: address, data until WLAST, then one response.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_ADDR:  if (aw_fire) wr_next = W_DATA;
            W_DATA:  if (w_fire && axi.wlast) wr_next = W_RESP;
            W_RESP:  if (b_fire) wr_next = W_ADDR;
            default: wr_next = W_ADDR;
        endcase
    end

    // Write channel outputs: every write completes with SLVERR.
    always_comb begin
        axi.awready = active && (wr_state == W_ADDR);
        axi.wready  = active && (wr_state == W_DATA);
        axi.bvalid  = active && (wr_state == W_RESP);
        axi.bresp   = 2'b10;
        axi.bid     = write_id;
    end

    assign aw_fire = axi.awvalid && axi.awready;
    assign w_fire  = axi.wvalid && axi.wready;
    assign b_fire  = axi.bvalid && axi.bready;

    // Remember the write ID for the response.
    always_ff @(posedge clk) begin
        if (!resetn)      write_id <= '0;
        else if (aw_fire) write_id <= axi.awid;
    end
endmodule

// File: tb/tb_abm_merge_reader.sv
// Directed bench for abm_merge_reader: a 4-bank RD_LAT=1 instance for most
// scenarios and a 2-bank RD_LAT=3 instance for backpressure.
module tb_abm_merge_reader;
    localparam int DW  = 32;
    localparam int AW  = 14;
    localparam int IDW = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [1:0]        merge_mode = 2'd0;
    logic [AW-1:0]     ram_addr1, ram_addr3;
    logic              ram_rden1, ram_rden3;
    logic [4*DW-1:0]   ram_data1;
    logic [2*DW-1:0]   ram_data3;
    logic [AW-1:0]     ram_a1;
    logic [AW-1:0]     a3_s [3];
    int                pattern = 0;
    int                rden_count1 = 0;
    int                rden_count3 = 0;
    int                checks = 0;
    int                fails = 0;

    logic [31:0]       got_data [300];
    logic [1:0]        got_resp [300];
    logic              got_last [300];
    logic [IDW-1:0]    got_id   [300];
    int                nbeats, first_cyc, last_cyc;

    abm_merge_reader_if #(.DW(DW), .IDW(IDW)) if1();
    abm_merge_reader_if #(.DW(DW), .IDW(IDW)) if3();

    abm_merge_reader #(.DW(DW), .AW(AW), .NRAM(4), .RD_LAT(1), .IDW(IDW)) dut (
        .clk(clk), .resetn(resetn), .merge_mode(merge_mode),
        .ram_addr(ram_addr1), .ram_rden(ram_rden1), .ram_data(ram_data1), .axi(if1)
    );

    abm_merge_reader #(.DW(DW), .AW(AW), .NRAM(2), .RD_LAT(3), .IDW(IDW)) dut3 (
        .clk(clk), .resetn(resetn), .merge_mode(merge_mode),
        .ram_addr(ram_addr3), .ram_rden(ram_rden3), .ram_data(ram_data3), .axi(if3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bank_word(input int pat, input int k, input logic [13:0] a);
        logic [31:0] w;
        w = '0;
        case (pat)
            0: if (a == 14'd5) w = 32'd1 << k;
            1: w = {24'd0, a[7:0]} << (8 * k);
            2: case (k)
                   0:       w = 32'hA5A5_A5A5;
                   1:       w = 32'h5A5A_FFFF;
                   2:       w = 32'hFFFF_00FF;
                   default: w = 32'hFFFF_FFFF;
               endcase
            default: if (k == 0) w = {18'd0, a};
        endcase
        return w;
    endfunction

    // RAM models: one-clock latency for dut, three for dut3.
    always @(posedge clk) begin
        ram_a1  <= ram_addr1;
        a3_s[0] <= ram_addr3;
        a3_s[1] <= a3_s[0];
        a3_s[2] <= a3_s[1];
        if (ram_rden1) rden_count1 <= rden_count1 + 1;
        if (ram_rden3) rden_count3 <= rden_count3 + 1;
    end

    always_comb begin
        ram_data1 = '0;
        ram_data3 = '0;
        for (int k = 0; k < 4; k++) ram_data1[k*DW +: DW] = bank_word(pattern, k, ram_a1);
        for (int k = 0; k < 2; k++) ram_data3[k*DW +: DW] = bank_word(pattern, k, a3_s[2]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_bus();
        {if1.araddr, if1.arlen, if1.arid, if1.arsize, if1.arburst, if1.arlock} = '0;
        {if1.arcache, if1.arprot, if1.arqos, if1.arvalid, if1.rready} = '0;
        {if1.awaddr, if1.awlen, if1.awid, if1.awsize, if1.awburst, if1.awlock} = '0;
        {if1.awcache, if1.awprot, if1.awqos, if1.awvalid} = '0;
        {if1.wdata, if1.wstrb, if1.wlast, if1.wvalid, if1.bready} = '0;
        {if3.araddr, if3.arlen, if3.arid, if3.arsize, if3.arburst, if3.arlock} = '0;
        {if3.arcache, if3.arprot, if3.arqos, if3.arvalid, if3.rready} = '0;
        {if3.awaddr, if3.awlen, if3.awid, if3.awsize, if3.awburst, if3.awlock} = '0;
        {if3.awcache, if3.awprot, if3.awqos, if3.awvalid} = '0;
        {if3.wdata, if3.wstrb, if3.wlast, if3.wvalid, if3.bready} = '0;
    endtask

    // Issues one AR on dut and collects beats with RREADY held high.
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [IDW-1:0] id, output bit hs_ok);
        nbeats = 0; first_cyc = -1; last_cyc = -1;
        got_data[0] = 'x;
        if1.araddr = addr; if1.arlen = len; if1.arid = id;
        if1.arvalid = 1'b1; if1.rready = 1'b1;
        hs_ok = 1'b0;
        for (int i = 0; i < 20 && !hs_ok; i++) begin
            if (if1.arready) hs_ok = 1'b1;
            tick();
        end
        if1.arvalid = 1'b0;
        for (int c = 0; c < int'(len) + 60 && nbeats < int'(len) + 1; c++) begin
            if (if1.rvalid) begin
                got_data[nbeats] = if1.rdata;
                got_resp[nbeats] = if1.rresp;
                got_last[nbeats] = if1.rlast;
                got_id[nbeats]   = if1.rid;
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                nbeats++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({if1.arready, if1.awready, if1.wready, if1.rvalid, if1.bvalid, ram_rden1} !== 6'b0) begin
            fails++; $display("[TB] FAIL reset_outputs: got %b, expected 000000",
                {if1.arready, if1.awready, if1.wready, if1.rvalid, if1.bvalid, ram_rden1});
        end
        checks++;
        if ({if3.arready, if3.awready, if3.rvalid, ram_rden3} !== 4'b0) begin
            fails++; $display("[TB] FAIL reset_outputs3: got %b, expected 0000",
                {if3.arready, if3.awready, if3.rvalid, ram_rden3});
        end
        resetn = 1'b1;
        checks++;
        if (if1.arready !== 1'b0) begin
            fails++; $display("[TB] FAIL arready_release_cycle: got %b, expected 0", if1.arready);
        end
        tick();
        checks++;
        if ({if1.arready, if1.awready, if3.arready} !== 3'b111) begin
            fails++; $display("[TB] FAIL ready_after_reset: got %b, expected 111",
                {if1.arready, if1.awready, if3.arready});
        end
    endtask

    task automatic test_single();
        pattern = 0; merge_mode = 2'd0;
        if1.araddr = 32'd20; if1.arlen = 8'd0; if1.arid = 4'd3;
        if1.arvalid = 1'b1; if1.rready = 1'b1;
        checks++;
        if (if1.arready !== 1'b1) begin
            fails++; $display("[TB] FAIL single_arready: got %b, expected 1", if1.arready);
        end
        tick();
        if1.arvalid = 1'b0;
        checks++;
        if ({ram_rden1, ram_addr1} !== {1'b1, 14'd5}) begin
            fails++; $display("[TB] FAIL single_issue: got rden=%b addr=%0d, expected rden=1 addr=5",
                ram_rden1, ram_addr1);
        end
        tick();
        checks++;
        if (if1.rvalid !== 1'b0) begin
            fails++; $display("[TB] FAIL single_early_rvalid: got %b, expected 0", if1.rvalid);
        end
        tick();
        checks++;
        if ({if1.rvalid, if1.rdata, if1.rid, if1.rlast, if1.rresp} !== {1'b1, 32'hF, 4'd3, 1'b1, 2'b00}) begin
            fails++; $display("[TB] FAIL single_beat: got v=%b d=%h id=%0d last=%b resp=%0d, expected v=1 d=f id=3 last=1 resp=0",
                if1.rvalid, if1.rdata, if1.rid, if1.rlast, if1.rresp);
        end
        tick();
        checks++;
        if (if1.rvalid !== 1'b0) begin
            fails++; $display("[TB] FAIL single_extra_beat: got %b, expected 0", if1.rvalid);
        end
    endtask

    task automatic test_streaming();
        bit ok;
        logic [7:0] b;
        pattern = 1; merge_mode = 2'd0;
        run_burst(32'd0, 8'd255, 4'd1, ok);
        checks++;
        if ({ok, nbeats == 256} !== 2'b11) begin
            fails++; $display("[TB] FAIL stream_count: got hs=%b beats=%0d, expected hs=1 beats=256", ok, nbeats);
        end
        checks++;
        if (last_cyc - first_cyc !== 255) begin
            fails++; $display("[TB] FAIL stream_no_bubbles: got span=%0d, expected 255", last_cyc - first_cyc);
        end
        for (int i = 0; i < nbeats && i < 256; i++) begin
            b = 8'(i);
            checks++;
            if ({got_data[i], got_last[i], got_id[i], got_resp[i]} !== {{4{b}}, i == 255, 4'd1, 2'b00}) begin
                fails++; $display("[TB] FAIL stream_beat%0d: got d=%h last=%b id=%0d resp=%0d, expected d=%h last=%b id=1 resp=0",
                    i, got_data[i], got_last[i], got_id[i], got_resp[i], {4{b}}, i == 255);
            end
        end
        tick(); tick(); tick();
        checks++;
        if (if1.rvalid !== 1'b0) begin
            fails++; $display("[TB] FAIL stream_trailing: got %b, expected 0", if1.rvalid);
        end
    endtask

    task automatic test_modes();
        bit ok;
        logic [31:0] expv [4];
        expv[0] = 32'hFFFF_FFFF; expv[1] = 32'h0000_00A5;
        expv[2] = 32'hFFFF_A55A; expv[3] = 32'hA5A5_A5A5;
        pattern = 2;
        for (int m = 0; m < 4; m++) begin
            merge_mode = 2'(m);
            run_burst(32'd36, 8'd0, IDW'(m), ok);
            checks++;
            if ({ok, nbeats == 1, got_data[0]} !== {2'b11, expv[m]}) begin
                fails++; $display("[TB] FAIL mode%0d: got hs=%b beats=%0d d=%h, expected hs=1 beats=1 d=%h",
                    m, ok, nbeats, got_data[0], expv[m]);
            end
        end
        merge_mode = 2'd0;
    endtask

    task automatic test_wrap();
        bit ok;
        pattern = 3;
        run_burst(32'h0000_FFFC, 8'd1, 4'd2, ok);
        checks++;
        if ({ok, nbeats == 2} !== 2'b11) begin
            fails++; $display("[TB] FAIL wrap_count: got hs=%b beats=%0d, expected hs=1 beats=2", ok, nbeats);
        end
        checks++;
        if ({got_data[0], got_last[0], got_resp[0]} !== {32'd16383, 1'b0, 2'b00}) begin
            fails++; $display("[TB] FAIL wrap_beat0: got d=%0d last=%b resp=%0d, expected d=16383 last=0 resp=0",
                got_data[0], got_last[0], got_resp[0]);
        end
        checks++;
        if ({got_data[1], got_last[1], got_resp[1]} !== {32'd0, 1'b1, 2'b00}) begin
            fails++; $display("[TB] FAIL wrap_beat1: got d=%0d last=%b resp=%0d, expected d=0 last=1 resp=0",
                got_data[1], got_last[1], got_resp[1]);
        end
    endtask

    task automatic test_error();
        bit ok;
        pattern = 3;
        run_burst(32'h8000_001C, 8'd2, 4'd5, ok);
        checks++;
        if ({ok, nbeats == 3} !== 2'b11) begin
            fails++; $display("[TB] FAIL err_count: got hs=%b beats=%0d, expected hs=1 beats=3", ok, nbeats);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({got_data[i], got_resp[i], got_last[i]} !== {32'(7 + i), 2'b10, i == 2}) begin
                fails++; $display("[TB] FAIL err_beat%0d: got d=%0d resp=%0d last=%b, expected d=%0d resp=2 last=%b",
                    i, got_data[i], got_resp[i], got_last[i], 7 + i, i == 2);
            end
        end
        run_burst(32'h0001_0004, 8'd0, 4'd5, ok);
        checks++;
        if ({ok, nbeats == 1, got_data[0], got_resp[0]} !== {2'b11, 32'd1, 2'b10}) begin
            fails++; $display("[TB] FAIL err_low_bit: got hs=%b beats=%0d d=%0d resp=%0d, expected hs=1 beats=1 d=1 resp=2",
                ok, nbeats, got_data[0], got_resp[0]);
        end
    endtask

    task automatic test_write();
        int r0, nb;
        bit aw_ok, w_ok;
        logic [1:0] bresp;
        logic [IDW-1:0] bid;
        r0 = rden_count1; nb = 0; aw_ok = 1'b0; w_ok = 1'b1;
        bresp = 'x; bid = 'x;
        if1.awaddr = 32'h100; if1.awlen = 8'd3; if1.awid = 4'd7; if1.awvalid = 1'b1;
        for (int i = 0; i < 20 && !aw_ok; i++) begin
            if (if1.awready) aw_ok = 1'b1;
            tick();
        end
        if1.awvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bit done;
            done = 1'b0;
            if1.wdata = 32'hDEAD_0000 + 32'(b); if1.wstrb = 4'hF;
            if1.wlast = (b == 3); if1.wvalid = 1'b1;
            for (int i = 0; i < 20 && !done; i++) begin
                if (if1.wready) done = 1'b1;
                tick();
            end
            if (!done) w_ok = 1'b0;
        end
        if1.wvalid = 1'b0; if1.wlast = 1'b0;
        if1.bready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (if1.bvalid) begin
                bresp = if1.bresp; bid = if1.bid; nb++;
            end
            tick();
        end
        if1.bready = 1'b0;
        checks++;
        if ({aw_ok, w_ok} !== 2'b11) begin
            fails++; $display("[TB] FAIL write_handshakes: got aw=%b w=%b, expected aw=1 w=1", aw_ok, w_ok);
        end
        checks++;
        if ({nb == 1, bresp, bid} !== {1'b1, 2'b10, 4'd7}) begin
            fails++; $display("[TB] FAIL write_bresp: got n=%0d resp=%0d id=%0d, expected n=1 resp=2 id=7", nb, bresp, bid);
        end
        checks++;
        if (rden_count1 - r0 !== 0) begin
            fails++; $display("[TB] FAIL write_no_reads: got %0d reads, expected 0", rden_count1 - r0);
        end
    endtask

    task automatic test_backpressure();
        bit ok, prev_stall;
        int base, popped, outst, max_out, n;
        logic [38:0] prev_beat, cur_beat;
        logic [31:0] d3 [16];
        logic        l3 [16];
        pattern = 3; merge_mode = 2'd0;
        base = rden_count3; popped = 0; max_out = 0; n = 0; ok = 1'b0;
        prev_stall = 1'b0; prev_beat = '0;
        if3.araddr = 32'd160; if3.arlen = 8'd15; if3.arid = 4'd9;
        if3.arvalid = 1'b1; if3.rready = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (if3.arready) ok = 1'b1;
            tick();
        end
        if3.arvalid = 1'b0;
        for (int c = 0; c < 200 && n < 16; c++) begin
            if3.rready = (c % 3 == 0);
            outst = (rden_count3 - base) - popped;
            if (outst > max_out) max_out = outst;
            cur_beat = {if3.rdata, if3.rresp, if3.rid, if3.rlast};
            if (prev_stall) begin
                checks++;
                if ({if3.rvalid, cur_beat} !== {1'b1, prev_beat}) begin
                    fails++; $display("[TB] FAIL bp_hold_c%0d: got v=%b beat=%h, expected v=1 beat=%h",
                        c, if3.rvalid, cur_beat, prev_beat);
                end
            end
            if (if3.rvalid && if3.rready) begin
                d3[n] = if3.rdata; l3[n] = if3.rlast;
                popped++; n++;
            end
            prev_stall = if3.rvalid && !if3.rready;
            prev_beat  = cur_beat;
            tick();
        end
        if3.rready = 1'b0;
        checks++;
        if ({ok, n == 16} !== 2'b11) begin
            fails++; $display("[TB] FAIL bp_count: got hs=%b beats=%0d, expected hs=1 beats=16", ok, n);
        end
        checks++;
        if (max_out !== 5) begin
            fails++; $display("[TB] FAIL bp_outstanding: got max=%0d, expected 5", max_out);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if ({d3[i], l3[i]} !== {32'(40 + i), i == 15}) begin
                fails++; $display("[TB] FAIL bp_beat%0d: got d=%0d last=%b, expected d=%0d last=%b",
                    i, d3[i], l3[i], 40 + i, i == 15);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, hit;
        int n;
        pattern = 3; merge_mode = 2'd0;
        n = 0; hit = 1'b0; ok = 1'b0;
        if1.araddr = 32'd64; if1.arlen = 8'd7; if1.arid = 4'd4;
        if1.arvalid = 1'b1; if1.rready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (if1.arready) ok = 1'b1;
            tick();
        end
        if1.arvalid = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            if (if1.rvalid) begin
                if (n == 2) begin
                    resetn = 1'b0; hit = 1'b1;
                end
                n++;
            end
            if (!hit) tick();
        end
        tick();
        checks++;
        if ({ok, hit} !== 2'b11) begin
            fails++; $display("[TB] FAIL midreset_reach: got hs=%b beat2=%b, expected 11", ok, hit);
        end
        checks++;
        if ({if1.arready, if1.awready, if1.wready, if1.rvalid, if1.bvalid, ram_rden1} !== 6'b0) begin
            fails++; $display("[TB] FAIL midreset_outputs: got %b, expected 000000",
                {if1.arready, if1.awready, if1.wready, if1.rvalid, if1.bvalid, ram_rden1});
        end
        resetn = 1'b1;
        tick(); tick();
        run_burst(32'd400, 8'd0, 4'd6, ok);
        checks++;
        if ({ok, nbeats == 1, got_data[0], got_last[0], got_id[0], got_resp[0]} !== {2'b11, 32'd100, 1'b1, 4'd6, 2'b00}) begin
            fails++; $display("[TB] FAIL midreset_followup: got hs=%b beats=%0d d=%0d last=%b id=%0d resp=%0d, expected hs=1 beats=1 d=100 last=1 id=6 resp=0",
                ok, nbeats, got_data[0], got_last[0], got_id[0], got_resp[0]);
        end
    endtask

    initial begin
        init_bus();
        test_reset();
        test_single();
        test_streaming();
        test_modes();
        test_wrap();
        test_error();
        test_write();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
